// File: rtl/snoop_responder.sv
// MSI snoop responder: looks up the local line on a bus snoop, supplies data and downgrades.
// Optional macro SNOOP_FLUSH_EN adds a memory flush after an exclusive line is supplied for GetS.
module snoop_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned BEATS   = 4,
    parameter int unsigned BEAT_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               snoop_in,
    input  logic [1:0]         snoop_func,
    input  logic [ADDR_W-1:0]  snoop_addr,
    output logic               tag_req,
    input  logic               tag_gnt,
    output logic [INDEX_W-1:0] tag_idx,
    input  logic [1:0]         tag_stat,
    input  logic               tag_match,
    output logic               stat_wr,
    output logic [1:0]         stat_new,
    output logic               data_rd,
    output logic [BEAT_W-1:0]  data_beat,
    input  logic [DATA_W-1:0]  data_in,
    output logic               snoop_hit,
    output logic               snoop_ready,
    output logic               snoop_valid,
    output logic [DATA_W-1:0]  snoop_data,
    output logic               mem_wr,
    output logic               mem_cs,
    input  logic               mem_ready,
    output logic               busy
);

    localparam logic [1:0] FuncGetS = 2'b10;
    localparam logic [1:0] FuncGetX = 2'b01;
    localparam logic [1:0] StatExcl = 2'b11;
    localparam logic [1:0] StatShrd = 2'b10;
    localparam logic [1:0] StatInvl = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLook,
        StSupply,
        StFlush,
        StUpdate
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          func_q, func_d;
    logic [INDEX_W-1:0]  idx_q, idx_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                hit_q, hit_d;
    logic                wr_q, wr_d;
    logic [1:0]          tgt_q, tgt_d;
    logic                flush_q, flush_d;
    logic                in_q;
    logic                valid_q;
    logic [DATA_W-1:0]   data_q;
    logic                is_getx;

    assign is_getx = (func_q == FuncGetX);

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        hit_d   = hit_q;
        wr_d    = wr_q;
        tgt_d   = tgt_q;
        flush_d = flush_q;
        unique case (state_q)
            StIdle: begin
                if (snoop_in && !in_q && (snoop_func == FuncGetS || snoop_func == FuncGetX)) begin
                    func_d  = snoop_func;
                    idx_d   = snoop_addr[INDEX_W-1:0];
                    state_d = StReq;
                end
            end
            StReq: begin
                if (tag_gnt) state_d = StLook;
            end
            StLook: begin
                hit_d   = 1'b0;
                wr_d    = 1'b0;
                tgt_d   = StatInvl;
                flush_d = 1'b0;
                state_d = StIdle;
                if (tag_match) begin
                    if (tag_stat == StatExcl) begin
                        hit_d   = 1'b1;
                        wr_d    = 1'b1;
                        tgt_d   = is_getx ? StatInvl : StatShrd;
                        flush_d = !is_getx;
                        state_d = StSupply;
                    end else if (tag_stat == StatShrd) begin
                        // A shared copy only needs to answer reads; GetX just drops it.
                        if (is_getx) begin
                            wr_d    = 1'b1;
                            state_d = StUpdate;
                        end else begin
                            hit_d   = 1'b1;
                            tgt_d   = StatShrd;
                            state_d = StSupply;
                        end
                    end
                end
            end
            StSupply: begin
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d = '0;
`ifdef SNOOP_FLUSH_EN
                    state_d = flush_q ? StFlush : StUpdate;
`else
                    state_d = StUpdate;
`endif
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            StFlush: begin
`ifdef SNOOP_FLUSH_EN
                if (mem_ready) state_d = StUpdate;
`else
                state_d = StUpdate;
`endif
            end
            StUpdate: begin
                hit_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            func_q  <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            hit_q   <= 1'b0;
            wr_q    <= 1'b0;
            tgt_q   <= '0;
            flush_q <= 1'b0;
            // Preset high so a request already asserted at reset release is not a new edge.
            in_q    <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            hit_q   <= hit_d;
            wr_q    <= wr_d;
            tgt_q   <= tgt_d;
            flush_q <= flush_d;
            in_q    <= snoop_in;
            valid_q <= data_rd;
            if (data_rd) data_q <= data_in;
        end
    end

    assign busy        = (state_q != StIdle);
    assign tag_req     = busy;
    assign tag_idx     = idx_q;
    assign data_rd     = (state_q == StSupply);
    assign data_beat   = beat_q;
    assign stat_wr     = (state_q == StUpdate) && wr_q;
    assign stat_new    = stat_wr ? tgt_q : 2'b00;
    assign snoop_hit   = hit_q;
    assign snoop_ready = (state_q == StUpdate) && hit_q;
    assign snoop_valid = valid_q;
    assign snoop_data  = data_q;

`ifdef SNOOP_FLUSH_EN
    assign mem_wr = (state_q == StFlush);
    assign mem_cs = (state_q == StFlush);

    logic unused_bits;
    assign unused_bits = ^snoop_addr[ADDR_W-1:INDEX_W];
`else
    assign mem_wr = 1'b0;
    assign mem_cs = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{snoop_addr[ADDR_W-1:INDEX_W], mem_ready, flush_q};
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: expected beats and state writes are queued at stimulus
// time and popped as the DUT emits them; per-transaction cycle counts are checked afterwards.
module tb_snoop_responder;

`ifdef SNOOP_FLUSH_EN
    localparam bit FlushEn = 1'b1;
`else
    localparam bit FlushEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       snoop_in;
    logic [1:0] snoop_func;
    logic [7:0] snoop_addr;
    logic       tag_req;
    logic       tag_gnt;
    logic [3:0] tag_idx;
    logic [1:0] tag_stat;
    logic       tag_match;
    logic       stat_wr;
    logic [1:0] stat_new;
    logic       data_rd;
    logic [1:0] data_beat;
    logic [7:0] data_in;
    logic       snoop_hit;
    logic       snoop_ready;
    logic       snoop_valid;
    logic [7:0] snoop_data;
    logic       mem_wr;
    logic       mem_cs;
    logic       mem_ready;
    logic       busy;

    logic [7:0] data_base;
    logic [20:0] outs;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_data[$];
    logic [1:0] exp_stat[$];

    always #5 clk = ~clk;

    assign data_in = data_rd ? (data_base + 8'(data_beat)) : 8'h00;
    assign outs = {tag_req, stat_wr, stat_new, data_rd, data_beat, snoop_hit, snoop_ready,
                   snoop_valid, snoop_data, mem_wr, mem_cs, busy};

    snoop_responder dut (
        .clk        (clk),
        .reset      (reset),
        .snoop_in   (snoop_in),
        .snoop_func (snoop_func),
        .snoop_addr (snoop_addr),
        .tag_req    (tag_req),
        .tag_gnt    (tag_gnt),
        .tag_idx    (tag_idx),
        .tag_stat   (tag_stat),
        .tag_match  (tag_match),
        .stat_wr    (stat_wr),
        .stat_new   (stat_new),
        .data_rd    (data_rd),
        .data_beat  (data_beat),
        .data_in    (data_in),
        .snoop_hit  (snoop_hit),
        .snoop_ready(snoop_ready),
        .snoop_valid(snoop_valid),
        .snoop_data (snoop_data),
        .mem_wr     (mem_wr),
        .mem_cs     (mem_cs),
        .mem_ready  (mem_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input logic [1:0] func, input logic [1:0] stat, input logic match,
                           input int gw, input int mw, input logic [7:0] base);
        logic getx, hit, wr, fl, done;
        int f, exp_busy;
        int busy_n, req_n, hit_n, valid_n, ready_n, ready_k, memwr_n, wr_k;
        logic [7:0] addr;
        getx = (func == 2'b01);
        hit  = match && (stat == 2'b11 || (stat == 2'b10 && !getx));
        wr   = match && (stat == 2'b11 || (stat == 2'b10 && getx));
        fl   = FlushEn && match && stat == 2'b11 && !getx;
        f    = fl ? mw : 0;
        exp_busy = hit ? 7 + gw + f : (wr ? 3 + gw : 2 + gw);
        if (hit) for (int b = 0; b < 4; b++) exp_data.push_back(base + 8'(b));
        if (wr) exp_stat.push_back(getx ? 2'b00 : 2'b10);
        busy_n = 0; req_n = 0; hit_n = 0; valid_n = 0; ready_n = 0; ready_k = 0;
        memwr_n = 0; wr_k = 0; done = 1'b0;

        @(negedge clk);
        snoop_in = 1'b0;
        @(negedge clk);
        addr       = 8'($urandom);
        snoop_func = func;
        snoop_addr = addr;
        tag_stat   = stat;
        tag_match  = match;
        data_base  = base;
        tag_gnt    = 1'b0;
        mem_ready  = 1'b0;
        snoop_in   = 1'b1;

        for (int k = 1; k <= 80 && !done; k++) begin
            @(negedge clk);
            if (k == 1) check("tag_idx", 32'(tag_idx), 32'(addr[3:0]));
            if (busy) busy_n++;
            if (tag_req) req_n++;
            if (snoop_hit) hit_n++;
            if (mem_wr) memwr_n++;
            if (mem_cs != mem_wr) check("mem_cs", 32'(mem_cs), 32'(mem_wr));
            if (snoop_valid) begin
                valid_n++;
                if (exp_data.size() == 0) check("data_extra", 1, 0);
                else check("snoop_data", 32'(snoop_data), 32'(exp_data.pop_front()));
            end
            if (stat_wr) begin
                wr_k = k;
                if (exp_stat.size() == 0) check("stat_extra", 1, 0);
                else check("stat_new", 32'(stat_new), 32'(exp_stat.pop_front()));
            end
            if (snoop_ready) begin
                ready_n++;
                ready_k = k;
                check("ready_with_valid", 32'(snoop_valid), 32'(f == 0));
            end
            done = !busy && k >= 2;
            tag_gnt   = (k > gw);
            mem_ready = mem_wr && (memwr_n >= mw);
            if (k == 3) snoop_in = 1'b0;
            if (k == 5 && busy) snoop_in = 1'b1;
        end
        if (!done) check("timeout", 0, 1);
        check("busy_cycles", 32'(busy_n), 32'(exp_busy));
        check("tag_req_cycles", 32'(req_n), 32'(exp_busy));
        check("hit_cycles", 32'(hit_n), hit ? 32'(5 + f) : 32'd0);
        check("valid_cycles", 32'(valid_n), hit ? 32'd4 : 32'd0);
        check("ready_count", 32'(ready_n), 32'(hit));
        if (hit) check("ready_latency", 32'(ready_k), 32'(7 + gw + f));
        if (wr) check("stat_wr_cycle", 32'(wr_k), 32'(exp_busy));
        check("mem_wr_cycles", 32'(memwr_n), 32'(f));
        check("beat_wrap", 32'(data_beat), 0);
        check("data_left", 32'(exp_data.size()), 0);
        check("stat_left", 32'(exp_stat.size()), 0);
        exp_data.delete();
        exp_stat.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("no_retrigger", 32'(busy), 0);
        end
    endtask

    initial begin
        bit found;
        reset = 1'b0; snoop_in = 1'b0; snoop_func = 2'b00; snoop_addr = 8'h00;
        tag_gnt = 1'b0; tag_stat = 2'b00; tag_match = 1'b0; mem_ready = 1'b0;
        data_base = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs), 0);
        reset = 1'b1;

        run_txn(2'b10, 2'b11, 1'b1, 0, 3, 8'hA0);  // excl GetS
        run_txn(2'b01, 2'b10, 1'b1, 0, 1, 8'hB0);  // shrd GetX
        run_txn(2'b10, 2'b10, 1'b1, 0, 1, 8'hC0);  // shrd GetS
        run_txn(2'b01, 2'b11, 1'b1, 0, 1, 8'h50);  // excl GetX
        run_txn(2'b10, 2'b11, 1'b0, 0, 1, 8'h60);  // no match
        run_txn(2'b01, 2'b00, 1'b1, 0, 1, 8'h70);  // invalid line
        run_txn(2'b10, 2'b11, 1'b1, 5, 1, 8'h10);  // late grant
        run_txn(2'b10, 2'b11, 1'b1, 2, 1, 8'hE0);  // short flush

        // NOP functions never start a transaction
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            snoop_in = 1'b0;
            @(negedge clk);
            snoop_func = (n == 0) ? 2'b11 : 2'b00;
            snoop_in = 1'b1;
            tag_gnt = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("nop_busy", 32'(busy), 0);
            end
        end

        // Reset during SUPPLY beat 2, request held high through release
        @(negedge clk);
        snoop_in = 1'b0;
        @(negedge clk);
        snoop_func = 2'b10; tag_stat = 2'b11; tag_match = 1'b1; tag_gnt = 1'b1;
        data_base = 8'h30; snoop_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = data_rd && (data_beat == 2'd2);
        end
        check("reach_beat2", 32'(found), 1);
        #1 reset = 1'b0;
        #1 check("async_reset_outs", 32'(outs), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_req_ignored", 32'(busy), 0);
        end
        run_txn(2'b01, 2'b11, 1'b1, 0, 1, 8'h90);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Bus-side responder of the MSI snooping protocol. One instance sits beside each cache controller.
- Watches snoop requests issued by other caches' controllers and looks up the local tag/state array.
- Drives snoop_hit, snoop_ready and the data beats back onto the bus.
- Applies the MSI downgrade or invalidation to the local line.

Parameters:
- ADDR_W, 8, snoop address width.
- INDEX_W, 4, tag-array index width; tag_idx = latched snoop_addr[INDEX_W-1:0].
- DATA_W, 8, bus data beat width.
- BEATS, 4, data beats per cache line (power of 2, >=2).
- BEAT_W, 2, beat counter width = log2(BEATS).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- snoop_in  in  1  snoop request from bus, level; a new request is recognised on its rising edge only.
- snoop_func  in  2  10=GetS (bus read), 01=GetX (write miss/upgrade), 00/11=NOP.
- snoop_addr  in  ADDR_W  snoop address; sampled with snoop_in rise.
- tag_req  out  1  request for the tag array; held from request until the transaction ends.
- tag_gnt  in  1  tag array granted; level.
- tag_idx  out  INDEX_W  latched index.
- tag_stat  in  2  line state: 11=excl, 10=shrd, 00=invl; valid the cycle after grant.
- tag_match  in  1  tag compare result, same timing as tag_stat.
- stat_wr  out  1  one-cycle state write strobe.
- stat_new  out  2  new state written on stat_wr.
- data_rd  out  1  data array read; data_in valid in the same cycle (combinational array).
- data_beat  out  BEAT_W  beat being read.
- data_in  in  DATA_W  line data.
- snoop_hit  out  1  this cache supplies the line.
- snoop_ready  out  1  one-cycle pulse: last beat on bus, transaction complete.
- snoop_valid  out  1  snoop_data valid.
- snoop_data  out  DATA_W  registered beat data.
- mem_wr, mem_cs  out  1  flush to memory (see Optional Feature).
- mem_ready  in  1  memory flush acknowledged.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - FSM returns to IDLE; all outputs 0; beat counter 0.
  - snoop_in edge detector preset to 1, so a request already held high at reset release is not taken.
- FSM states: IDLE, REQ, LOOK, SUPPLY, FLUSH, UPDATE.
- IDLE:
  - Rising snoop_in with func GetS/GetX: latch func and index, go to REQ.
  - Rising snoop_in with NOP func: ignored, stay in IDLE.
- REQ:
  - tag_req=1.
  - Stay until tag_gnt is sampled 1, then go to LOOK.
  - tag_req stays 1 through LOOK/SUPPLY/FLUSH/UPDATE, so the line is locked against the local controller.
- LOOK: decide on tag_stat, tag_match.
  - No match, or invl: back to IDLE; no strobe, no snoop_hit, no snoop_ready (memory answers).
  - excl, GetS: snoop_hit<=1, go to SUPPLY; target state shrd.
  - excl, GetX: snoop_hit<=1, go to SUPPLY; target state invl.
  - shrd, GetS: snoop_hit<=1, go to SUPPLY; target state shrd (unchanged, no strobe).
  - shrd, GetX: snoop_hit stays 0, go to UPDATE; target state invl.
- SUPPLY:
  - BEATS cycles with data_rd=1, data_beat=0..BEATS-1.
  - snoop_data<=data_in and snoop_valid<=1 one cycle later.
  - After the final beat: go to FLUSH if excl+GetS and SNOOP_FLUSH_EN is defined, else UPDATE.
- FLUSH: mem_wr=mem_cs=1; hold until mem_ready is sampled 1, then go to UPDATE.
- UPDATE, one cycle:
  - stat_wr=1 with stat_new=target, except shrd+GetS where stat_wr=0.
  - snoop_ready=1 only if snoop_hit; on the path without FLUSH it coincides with the last snoop_valid.
  - snoop_hit cleared on exit; return to IDLE.
- Latency (tag_gnt tied 1, no flush): snoop_in sampled at edge T → snoop_ready high in the cycle after edge T+BEATS+2. That is 7 cycles for BEATS=4.
- snoop_in changes while busy: ignored. After completion, snoop_in must drop before another request is taken.
- snoop_in deasserted mid-transaction: no abort; the transaction completes.
- Beat counter wraps to 0 at exit.
- snoop_hit is 0 except from the LOOK→SUPPLY edge until the end of UPDATE.

Optional Feature:
- Macro SNOOP_FLUSH_EN.
- Defined: on excl+GetS, FLUSH runs after SUPPLY so memory commits the supplied line. snoop_ready is delayed until after mem_ready.
- Undefined: FLUSH is unreachable; mem_wr/mem_cs tied 0; mem_ready ignored; ports stay present.

Test Plan:
1. tag_gnt=1, stat=excl, match=1, GetS, data_in=beat+0xA0 → snoop_hit high 5 cycles; snoop_data A0,A1,A2,A3; snoop_ready with A3; stat_wr with stat_new=10.
2. stat=shrd, GetX → snoop_hit never 1, no snoop_valid; stat_wr with stat_new=00 two cycles after REQ; snoop_ready stays 0.
3. match=0 → back to IDLE after LOOK; no stat_wr, snoop_hit, or snoop_ready; busy high 2 cycles.
4. tag_gnt held 0 for 5 cycles → tag_req held; LOOK entered only after grant; total latency +5.
5. Reset pulled low during SUPPLY beat 2 → all outputs 0 immediately. With snoop_in held high at release, no new transaction until snoop_in toggles.
6. SNOOP_FLUSH_EN defined, excl+GetS, mem_ready after 3 cycles → mem_wr/mem_cs high 3 cycles, then UPDATE; snoop_ready 3 cycles later than in test 1. snoop_func=11 → ignored.
